// File: rtl/rand_range_sampler.sv
// Purpose: fetch one LFSR word per attempt and reduce it to a uniform value in [0, RANGE) by bounded rejection sampling.
// Latency: req -> out_valid in 4 cycles best case, +3 cycles per rejected sample, worst case 3*(MAX_RETRY+1)+1.
// Backpressure: result held stable in HOLD until out_valid & out_ready; req is ignored while busy (no queueing).
// Optional: define RAND_SAMPLER_STATS_EN to build the saturating reject_cnt counter (otherwise tied to zero).
module rand_range_sampler #(
    parameter int IN_W      = 28,
    parameter int OUT_W     = 10,
    parameter int RANGE     = 640,
    parameter int MAX_RETRY = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    output logic             lfsr_fetch,
    input  logic             lfsr_ack,
    input  logic [IN_W-1:0]  lfsr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             busy,
    output logic [15:0]      reject_cnt
);

    // Parameter legality: the fold (cand - RANGE) is only guaranteed < RANGE
    // when RANGE lies in the top half of the OUT_W-bit code space.
    if (RANGE > (1 << OUT_W)) begin : g_bad_range_hi
        $error("rand_range_sampler: RANGE exceeds 2^OUT_W");
    end
    if (RANGE <= (1 << (OUT_W - 1))) begin : g_bad_range_lo
        $error("rand_range_sampler: RANGE must exceed 2^(OUT_W-1)");
    end
    if (OUT_W > IN_W) begin : g_bad_width
        $error("rand_range_sampler: OUT_W wider than IN_W");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
        $error("rand_range_sampler: MAX_RETRY must be 1..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ACK,
        S_CHECK,
        S_HOLD
    } state_t;

    localparam logic [OUT_W:0]   L_RANGE     = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0] L_FOLD      = L_RANGE[OUT_W-1:0];
    localparam logic [3:0]       L_MAX_RETRY = 4'(MAX_RETRY);

    state_t             r_state;
    state_t             w_next;
    logic [OUT_W-1:0]   r_cand;
    logic [3:0]         r_retry;
    logic [OUT_W-1:0]   r_out_value;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_retry_left;
    logic               w_xfer;

    // Only the low OUT_W bits of the LFSR word are used; the rest are dropped.
    if (IN_W > OUT_W) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^lfsr_data[IN_W-1:OUT_W];
    end

    assign w_accept     = ({1'b0, r_cand} < L_RANGE);
    assign w_retry_left = (r_retry < L_MAX_RETRY);
    assign w_xfer       = r_out_valid & out_ready;

    assign out_valid = r_out_valid;
    assign out_value = r_out_value;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs; fetch is a single FETCH-state cycle,
    // and FETCH always moves on, so two back-to-back fetches are impossible.
    always_comb begin
        w_next     = r_state;
        lfsr_fetch = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                lfsr_fetch = 1'b1;
                w_next     = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (lfsr_ack) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!w_accept && w_retry_left) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_xfer) begin
                    w_next = req ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture candidate, count retries, produce accepted or folded result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand      <= '0;
            r_retry     <= '0;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_retry <= '0;
                end
                S_WAIT_ACK: begin
                    if (lfsr_ack) begin
                        r_cand <= lfsr_data[OUT_W-1:0];
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_out_value <= r_cand;
                        r_out_valid <= 1'b1;
                    end else if (w_retry_left) begin
                        r_retry <= r_retry + 4'd1;
                    end else begin
                        r_out_value <= r_cand - L_FOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_retry     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0] r_reject_cnt;

    // Saturating count of rejected samples; the final forced fold is not a reject.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reject_cnt <= '0;
        end else if (r_state == S_CHECK && !w_accept && w_retry_left
                     && r_reject_cnt != 16'hFFFF) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
        end
    end

    assign reject_cnt = r_reject_cnt;
`else
    assign reject_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rand_range_sampler.sv
// Bench for rand_range_sampler: an LFSR responder feeds words from a table, and
// a reference model picks the expected value straight from the sampling rules.
// Expected reject_cnt follows RAND_SAMPLER_STATS_EN.
module tb_rand_range_sampler;

    localparam int RANGE = 640;
    localparam int MODN  = 1024;
    localparam int MAXR  = 7;
`ifdef RAND_SAMPLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        lfsr_fetch;
    logic        lfsr_ack = 1'b0;
    logic [27:0] lfsr_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_value;
    logic        busy;
    logic [15:0] reject_cnt;

    int checks   = 0;
    int failures = 0;

    // Responder state (written only by the responder process).
    int fetch_cnt = 0;
    int dbl_fetch = 0;
    bit prev_fetch = 1'b0;
    int seen_gen  = 0;
    int rd_idx    = 0;
    int ack_timer = 0;
    int spur_done = 0;

    // Stimulus-side controls (written only by the main initial block).
    int          ack_delay = 0;
    int          load_gen  = 0;
    int          spur_req  = 0;
    logic [27:0] w_arr [8];
    int          rej_total = 0;

    rand_range_sampler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lfsr_fetch (lfsr_fetch),
        .lfsr_ack   (lfsr_ack),
        .lfsr_data  (lfsr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .busy       (busy),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    // LFSR model: ack 1+ack_delay cycles after each observed fetch, words from w_arr in order.
    always @(negedge clk) begin
        if (seen_gen != load_gen) begin
            seen_gen = load_gen;
            rd_idx   = 0;
        end
        lfsr_ack = 1'b0;
        if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0) begin
                lfsr_ack  = 1'b1;
                lfsr_data = (rd_idx < 8) ? w_arr[rd_idx] : 28'd0;
                rd_idx++;
            end
        end
        if (lfsr_fetch === 1'b1) begin
            fetch_cnt++;
            if (prev_fetch) dbl_fetch++;
            ack_timer = 1 + ack_delay;
        end
        prev_fetch = (lfsr_fetch === 1'b1);
        if (spur_done != spur_req) begin
            spur_done = spur_req;
            lfsr_ack  = 1'b1;
            lfsr_data = 28'h0000123;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: take words in order, low 10 bits as a number; first one below RANGE wins,
    // after MAXR rejections the next is folded by subtracting RANGE.
    function automatic int ref_pick(output int n);
        int v;
        for (int i = 0; i <= MAXR; i++) begin
            v = int'(w_arr[i]) % MODN;
            if (v < RANGE) begin
                n = i + 1;
                return v;
            end
        end
        n = MAXR + 1;
        return (int'(w_arr[MAXR]) % MODN) - RANGE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 8; i++) w_arr[i] = 28'($urandom);
        load_gen++;
    endtask

    task automatic set_low(input int i, input int low);
        w_arr[i] = {w_arr[i][27:10], 10'(low)};
    endtask

    // Called one cycle after req was sampled; waits for the result and checks it.
    task automatic finish_req(input string tag, input int base);
        int n;
        int lat;
        int exp_v;
        lat   = 1;
        exp_v = ref_pick(n);
        while (out_valid !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
        rej_total += n - 1;
        check({tag, ".latency"}, lat, 1 + n * (3 + ack_delay));
        check({tag, ".value"}, 32'(out_value), exp_v);
        check({tag, ".fetches"}, fetch_cnt - base, n);
        check({tag, ".reject_cnt"}, 32'(reject_cnt), STATS ? rej_total : 0);
    endtask

    task automatic request_and_check(input string tag);
        int base;
        base = fetch_cnt;
        req  = 1'b1;
        step();
        req  = 1'b0;
        finish_req(tag, base);
    endtask

    task automatic accept(input string tag);
        int w;
        w = $urandom_range(0, 2);
        repeat (w) step();
        check({tag, ".valid_before_accept"}, 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".valid_after_accept"}, 32'(out_valid), 0);
        check({tag, ".idle_after_accept"}, 32'(busy), 0);
    endtask

    initial begin
        int base;
        int k;
        bit stable;
        logic [9:0] hv;

        reset     = 1'b1;
        req       = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("reset.out_valid", 32'(out_valid), 0);
        check("reset.out_value", 32'(out_value), 0);
        check("reset.fetch", 32'(lfsr_fetch), 0);
        check("reset.busy", 32'(busy), 0);
        check("reset.reject_cnt", 32'(reject_cnt), 0);
        reset = 1'b0;
        step();

        // Single accepted sample.
        load_random();
        set_low(0, 300);
        request_and_check("basic300");
        accept("basic300");

        // Two rejections then accept.
        load_random();
        set_low(0, 700);
        set_low(1, 1000);
        set_low(2, 5);
        request_and_check("rej2");
        accept("rej2");

        // All rejected: forced fold 1023-640.
        load_random();
        for (int i = 0; i < 8; i++) set_low(i, 1023);
        request_and_check("fold");
        accept("fold");

        // Boundary candidates 639 (accept) and 640 (reject).
        load_random();
        set_low(0, 640);
        set_low(1, 639);
        request_and_check("edge");
        accept("edge");

        // Randomized requests with random ack delays and occasional forced rejects.
        for (int it = 0; it < 12; it++) begin
            ack_delay = $urandom_range(0, 3);
            load_random();
            k = $urandom_range(0, 8);
            for (int i = 0; i < k; i++) set_low(i, $urandom_range(RANGE, MODN - 1));
            request_and_check($sformatf("rnd%0d", it));
            accept($sformatf("rnd%0d", it));
        end
        ack_delay = 0;

        // Backpressure: result stable for 20 cycles, then transfer with req chains a fetch.
        load_random();
        request_and_check("hold");
        hv     = out_value;
        base   = fetch_cnt;
        stable = 1'b1;
        repeat (20) begin
            step();
            if (out_valid !== 1'b1 || out_value !== hv || busy !== 1'b1) stable = 1'b0;
        end
        check("hold.stable", 32'(stable), 1);
        check("hold.no_fetch", fetch_cnt - base, 0);
        load_random();
        base      = fetch_cnt;
        out_ready = 1'b1;
        req       = 1'b1;
        step();
        out_ready = 1'b0;
        req       = 1'b0;
        check("chain.valid_dropped", 32'(out_valid), 0);
        check("chain.fetch_next", 32'(lfsr_fetch), 1);
        finish_req("chain", base);
        accept("chain");

        // Spurious ack in IDLE must do nothing; then a slow (10-cycle) ack.
        base = fetch_cnt;
        spur_req++;
        step();
        step();
        check("spur.busy", 32'(busy), 0);
        check("spur.valid", 32'(out_valid), 0);
        check("spur.fetches", fetch_cnt - base, 0);
        ack_delay = 10;
        load_random();
        set_low(0, 800);
        request_and_check("slow");
        accept("slow");
        ack_delay = 0;

        // Reset while waiting for ack; the late ack must be ignored.
        ack_delay = 4;
        load_random();
        base = fetch_cnt;
        req  = 1'b1;
        step();
        req  = 1'b0;
        step();
        check("rst.busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        rej_total = 0;
        check("rst.busy", 32'(busy), 0);
        check("rst.valid", 32'(out_valid), 0);
        check("rst.fetch", 32'(lfsr_fetch), 0);
        check("rst.reject_cnt", 32'(reject_cnt), 0);
        step();
        step();
        reset = 1'b0;
        repeat (8) step();
        check("rst.after_ack_busy", 32'(busy), 0);
        check("rst.after_ack_valid", 32'(out_valid), 0);
        check("rst.after_ack_value", 32'(out_value), 0);
        check("rst.single_fetch", fetch_cnt - base, 1);
        ack_delay = 0;
        load_random();
        set_low(0, 999);
        request_and_check("post_rst");
        accept("post_rst");

        check("no_double_fetch", dbl_fetch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Downstream consumer of the 28-bit LFSR random source (fetch/ack/dir_X interface).
- On request, issues a one-cycle fetch, captures the new LFSR word on ack, and reduces it to a uniform value in [0, RANGE) by rejection sampling with a bounded retry count.
- Presents the result on a valid/ready handshake to game logic, e.g. spawn X coordinate or direction selection.

Parameters:
- IN_W, 28, width of LFSR word dir_X.
- OUT_W, 10, width of reduced output; must satisfy 2^(OUT_W-1) < RANGE <= 2^OUT_W.
- RANGE, 640, exclusive upper bound of output value.
- MAX_RETRY, 7, rejected samples tolerated before forced fold; 1..15.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  pulse or level; request one new random value.
- lfsr_fetch  out  1  one-cycle fetch strobe to LFSR.
- lfsr_ack  in  1  LFSR ack, high one cycle after the accepted fetch.
- lfsr_data  in  IN_W  LFSR word (dir_X), valid when lfsr_ack=1.
- out_valid  out  1  out_value holds a result.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_value  out  OUT_W  sampled value, 0..RANGE-1.
- busy  out  1  high in any state other than IDLE.
- reject_cnt  out  16  saturating count of rejected samples (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE; lfsr_fetch=0, out_valid=0, out_value=0, busy=0, retry counter=0, reject_cnt=0.
- States: IDLE, FETCH, WAIT_ACK, CHECK, HOLD.
- IDLE: if req=1 -> FETCH; retry counter cleared.
- FETCH: lfsr_fetch=1 for exactly this one cycle -> WAIT_ACK.
- WAIT_ACK: lfsr_fetch=0; wait indefinitely for lfsr_ack=1. On ack, capture cand=lfsr_data[OUT_W-1:0] -> CHECK. Upper bits are ignored.
- CHECK, normal path:
  - cand < RANGE: out_value<=cand, out_valid<=1 -> HOLD.
  - cand >= RANGE and retry < MAX_RETRY: retry+1, reject_cnt+1 -> FETCH.
  - cand >= RANGE and retry = MAX_RETRY: out_value<=cand-RANGE (fold), out_valid<=1 -> HOLD. The fold is not counted as a reject.
- HOLD: out_value and out_valid stable until out_valid&out_ready.
  - On transfer: out_valid<=0 next cycle; if req=1 in the same cycle -> FETCH, else IDLE.
- req is ignored outside IDLE and the HOLD transfer cycle; requests are not queued.
- Latency, best case: req at cycle 0 -> fetch at cycle 1 -> ack at cycle 2 -> out_valid at cycle 4 (CHECK at cycle 3).
- Each retry adds 3 cycles.
- Worst case: 3*(MAX_RETRY+1)+1 cycles after req.
- lfsr_ack arriving outside WAIT_ACK is ignored.
- lfsr_fetch is never asserted two cycles in a row, so the LFSR advances exactly one step per fetch.
- Reset mid-operation aborts immediately: no fetch is issued after reset asserts, and any pending result is discarded.
- Subtraction is OUT_W-bit unsigned; the parameter constraint guarantees the fold result is < RANGE.
- Elaboration error if RANGE > 2^OUT_W, RANGE <= 2^(OUT_W-1), or OUT_W > IN_W.

Optional Feature:
- Macro RAND_SAMPLER_STATS_EN.
- Defined: reject_cnt increments on every rejection, saturates at 16'hFFFF, and clears only on reset.
- Undefined: reject_cnt is tied to 0 and its counter logic is not synthesized; all other behaviour is identical.

Test Plan:
- Reset then req pulse; LFSR model returns lfsr_data[9:0]=300 on ack -> out_valid at cycle 4, out_value=300, exactly one fetch observed.
- Model returns 700, then 1000, then 5 -> two rejections, three fetches, out_value=5, reject_cnt=2 (with macro) or 0 (without).
- Model always returns 1023 -> 8 fetches total, out_value=383 (1023-640), reject_cnt=7.
- out_ready held low 20 cycles in HOLD -> out_value/out_valid stable, no fetch; raise out_ready with req=1 -> transfer then fetch on the next cycle.
- Delay ack by 10 cycles and inject a spurious ack while in IDLE -> no state change from the spurious ack; result still correct.
- Assert reset in WAIT_ACK, then deliver ack after release -> outputs at reset values, ack ignored, IDLE until next req.
